// File: rtl/mul_issue_queue_pkg.sv
// +--------------------------------------------------------------------+
// | mul_pkg : shared types for the multiplier issue queue               |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package mul_pkg;

  localparam int MUL_WIDTH      = 16;
  localparam int MUL_PROD_WIDTH = 2 * MUL_WIDTH;

  typedef struct packed {
    logic [MUL_WIDTH-1:0] multiplicand;
    logic [MUL_WIDTH-1:0] multiplier;
  } operand_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } issue_state_t;

  function automatic logic has_zero_operand(input operand_pair_t pair);
    return (pair.multiplicand == '0) || (pair.multiplier == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_issue_queue_fifo.sv
// +--------------------------------------------------------------------+
// | mul_operand_fifo : synchronous FIFO of operand pairs                |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_operand_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  operand_pair_t push_data,
  input  logic          pop,
  output operand_pair_t pop_data,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  operand_pair_t      r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [COUNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full     = (r_count == COUNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_push   = push & ~full;
  assign w_pop    = pop & ~empty;
  assign pop_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/mul_issue_queue.sv
// +--------------------------------------------------------------------+
// | mul_issue_queue : operand FIFO + issue FSM for sequential multiplier|
// | Optional zero-operand bypass: define MUL_ZERO_BYPASS_EN. Rev 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_issue_queue
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplier,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic [WIDTH-1:0]   mul_multiplier,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
);

  issue_state_t       r_state;
  issue_state_t       w_state_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_out_product;

  operand_pair_t w_push_pair;
  operand_pair_t w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_capture;
  logic          w_bypass;
  logic          w_release;

  assign w_push_pair.multiplicand = MUL_WIDTH'(in_multiplicand);
  assign w_push_pair.multiplier   = MUL_WIDTH'(in_multiplier);

  mul_operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (w_push_pair),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign in_ready         = ~w_full;
  assign mul_start        = (r_state == START);
  assign mul_multiplicand = r_mcand;
  assign mul_multiplier   = r_mplier;
  assign out_valid        = r_out_valid;
  assign out_product      = r_out_product;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // mul_done is only honoured in WAIT; a done seen in START is too early to be ours.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_bypass     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
          if (has_zero_operand(w_head)) begin
            w_bypass     = 1'b1;
            w_state_next = HOLD;
          end else begin
            w_state_next = START;
          end
`else
          w_state_next = START;
`endif
        end
      end
      START: w_state_next = WAIT;
      WAIT: begin
        if (mul_done) begin
          w_capture    = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
    end else begin
      if (w_pop) begin
        r_mcand  <= WIDTH'(w_head.multiplicand);
        r_mplier <= WIDTH'(w_head.multiplier);
      end
      if (w_capture) begin
        r_out_product <= mul_product;
        r_out_valid   <= 1'b1;
      end else if (w_bypass) begin
        r_out_product <= '0;
        r_out_valid   <= 1'b1;
      end else if (w_release) begin
        r_out_valid   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_issue_queue.sv
// +--------------------------------------------------------------------+
// | tb_mul_issue_queue : scoreboard bench with a behavioural multiplier |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mul_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_multiplicand;
  logic [15:0] in_multiplier;
  logic        mul_start;
  logic [15:0] mul_multiplicand;
  logic [15:0] mul_multiplier;
  logic        mul_done;
  logic [31:0] mul_product;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_product;

  mul_issue_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplicand  (in_multiplicand),
    .in_multiplier    (in_multiplier),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_done         (mul_done),
    .mul_product      (mul_product),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  int          start_count = 0;
  bit          busy = 0;
  bit          spur_en = 1;
  bit          lat_rand = 0;
  int          lat_cfg = 18;
  bit          rand_ready = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Behavioural multiplier: done pulses a fixed/random number of cycles after start.
  initial begin
    logic [15:0] la;
    logic [15:0] lb;
    int          cnt;
    la = '0; lb = '0; cnt = 0;
    mul_done = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      mul_product = $urandom;
      if (reset) begin
        busy = 0;
      end else if (mul_start) begin
        check("start_overlap", !busy, 64'(busy), 64'd0);
        busy = 1;
        la = mul_multiplicand;
        lb = mul_multiplier;
        cnt = lat_rand ? int'($urandom_range(1, 20)) : lat_cfg;
        start_count++;
        if (spur_en && $urandom_range(0, 1) == 1) begin
          mul_done = 1'b1;
          mul_product = ~(32'(la) * 32'(lb));
        end
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          check("operand_stable", {mul_multiplicand, mul_multiplier} == {la, lb},
                64'({mul_multiplicand, mul_multiplier}), 64'({la, lb}));
          mul_done = 1'b1;
          mul_product = 32'(la) * 32'(lb);
          busy = 0;
        end
      end else if (spur_en && $urandom_range(0, 5) == 0) begin
        mul_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  bit          prev_reset = 0;
  bit          prev_hold = 0;
  bit          prev_fire = 0;
  logic [31:0] prev_prod = '0;
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_reset = 1; prev_hold = 0; prev_fire = 0;
      end else begin
        if (prev_reset) begin
          check("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
          check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
          check("rst_mul_start", mul_start == 1'b0, 64'(mul_start), 64'd0);
          check("rst_operands", {mul_multiplicand, mul_multiplier} == 32'd0,
                64'({mul_multiplicand, mul_multiplier}), 64'd0);
          check("rst_out_product", out_product == 32'd0, 64'(out_product), 64'd0);
        end
        if (prev_hold) begin
          check("hold_valid", out_valid == 1'b1, 64'(out_valid), 64'd1);
          check("hold_product", out_product == prev_prod, 64'(out_product), 64'(prev_prod));
        end
        if (prev_fire)
          check("valid_one_cycle", out_valid == 1'b0, 64'(out_valid), 64'd0);
        if (in_valid && in_ready)
          exp_q.push_back(32'(in_multiplicand) * 32'(in_multiplier));
        prev_fire = 0; prev_hold = 0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1'b0, 64'(out_product), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("product", out_product == e, 64'(out_product), 64'(e));
          end
          prev_fire = 1;
        end else if (out_valid) begin
          prev_hold = 1;
          prev_prod = out_product;
        end
        prev_reset = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    in_valid = 1'b1; in_multiplicand = a; in_multiplier = b;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    check("send_timeout", guard < 500, 64'(guard), 64'd500);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 3000) begin
      guard++;
      @(negedge clk);
    end
    check("drain_timeout", guard < 3000, 64'(guard), 64'd3000);
    @(posedge clk); #1;
  endtask

  task automatic wait_cond_out_valid();
    int guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 200) begin guard++; @(negedge clk); end
    check("out_valid_timeout", guard < 200, 64'(guard), 64'd200);
  endtask

  task automatic wait_busy();
    int guard = 0;
    @(negedge clk);
    while (!busy && guard < 200) begin guard++; @(negedge clk); end
    check("busy_timeout", guard < 200, 64'(guard), 64'd200);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sc;
    logic [15:0] a;
    logic [15:0] b;
    reset = 1'b1; in_valid = 1'b0; in_multiplicand = '0; in_multiplier = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single pair, fixed 18-cycle latency.
    lat_rand = 0; lat_cfg = 18;
    sc = start_count;
    send(16'h0003, 16'h0005);
    drain();
    check("single_start_count", start_count - sc == 1, 64'(start_count - sc), 64'd1);

    // Result held with out_ready low while the FIFO fills behind it.
    out_ready = 1'b0; lat_cfg = 5;
    send(16'd7, 16'd9);
    wait_cond_out_valid();
    @(posedge clk); #1;
    sc = start_count;
    send(16'hFFFF, 16'hFFFF);
    send(16'd1, 16'd1);
    send(16'd2, 16'd2);
    send(16'd3, 16'd3);
    @(negedge clk);
    check("in_ready_full", in_ready == 1'b0, 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_multiplicand = 16'd4; in_multiplier = 16'd4;
    repeat (6) @(negedge clk);
    check("fifth_stalls", in_ready == 1'b0, 64'(in_ready), 64'd0);
    check("no_start_in_hold", start_count == sc, 64'(start_count - sc), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'd4, 16'd4);
    drain();

    // Reset while in WAIT with two pairs queued.
    lat_cfg = 30;
    send(16'd11, 16'd13);
    wait_busy();
    send(16'd21, 16'd2);
    send(16'd5, 16'd6);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("reset_idle_no_start", busy == 0, 64'(busy), 64'd0);

    // Zero operand: bypass skips the multiplier when enabled.
    lat_cfg = 4;
    sc = start_count;
    send(16'h0000, 16'h1234);
    drain();
`ifdef MUL_ZERO_BYPASS_EN
    check("zero_start_count", start_count == sc, 64'(start_count - sc), 64'd0);
`else
    check("zero_start_count", start_count - sc == 1, 64'(start_count - sc), 64'd1);
`endif

    // Randomised traffic.
    lat_rand = 1;
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      case ($urandom_range(0, 7))
        0:       a = 16'h0000;
        1:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1:       b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      send(a, b);
    end
    rand_ready = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
